// File: rtl/palette_ram_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : palette_ram_ctl_if
//  Description : CPU-side and render-side signal bundle for palette_ram_ctl.
//                master = PPU register file / pixel mux side,
//                slave  = palette memory controller.
//  Ports       : cpu_addr, cpu_din, cpu_write, cpu_read  (master -> slave)
//                cpu_dout, cpu_valid                     (slave -> master)
//                ppu_addr, greyscale                     (master -> slave)
//                ppu_dout, busy                          (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface palette_ram_ctl_if #(
    parameter int DATA_W = 6,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic              cpu_write;
    logic              cpu_read;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_valid;
    logic [ADDR_W-1:0] ppu_addr;
    logic              greyscale;
    logic [DATA_W-1:0] ppu_dout;
    logic              busy;

    modport master (
        output cpu_addr, cpu_din, cpu_write, cpu_read, ppu_addr, greyscale,
        input  cpu_dout, cpu_valid, ppu_dout, busy
    );

    modport slave (
        input  cpu_addr, cpu_din, cpu_write, cpu_read, ppu_addr, greyscale,
        output cpu_dout, cpu_valid, ppu_dout, busy
    );
endinterface
`default_nettype wire

// File: rtl/palette_ram_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : palette_ram_ctl
//  Description : Palette memory for the PPU. CPU read/write port with
//                registered read data, registered render read port with
//                greyscale masking, backdrop mirroring on both ports and a
//                clear sequencer that fills the array after reset.
//  Ports       : clk    - clock
//                reset  - synchronous, active-high
//                ce_i   - clock enable (reset acts regardless)
//                bus    - palette_ram_ctl_if.slave (CPU + render signals)
//  Revision    : 1.0  initial release
// ============================================================================
module palette_ram_ctl #(
    parameter int                DATA_W          = 6,
    parameter int                ADDR_W          = 5,
    parameter bit                MIRROR_BACKDROP = 1'b1,
    parameter bit                INIT_ON_RESET   = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VAL        = '0,
    parameter logic [DATA_W-1:0] GREY_MASK       = DATA_W'('h30)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce_i,
    palette_ram_ctl_if.slave       bus
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
    logic              cpu_valid_q, cpu_valid_d;
    logic [DATA_W-1:0] ppu_dout_q, ppu_dout_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] cpu_eff;
    logic [ADDR_W-1:0] ppu_eff;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] ppu_rd;

    // Backdrop mirroring: entries with addr[1:0]==0 share storage across
    // the background and sprite halves, so bit 4 is dropped.
    if (MIRROR_BACKDROP && ADDR_W >= 5) begin : g_mirror
        always_comb begin
            cpu_eff = bus.cpu_addr;
            ppu_eff = bus.ppu_addr;
            if (bus.cpu_addr[1:0] == 2'b00) cpu_eff[4] = 1'b0;
            if (bus.ppu_addr[1:0] == 2'b00) ppu_eff[4] = 1'b0;
        end
    end else begin : g_no_mirror
        assign cpu_eff = bus.cpu_addr;
        assign ppu_eff = bus.ppu_addr;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we      = 1'b0;
        mem_waddr   = cnt_q;
        mem_wdata   = INIT_VAL;
        cpu_dout_d  = cpu_dout_q;
        cpu_valid_d = 1'b0;

        // Render port reads the pre-write contents (read-first on collision).
        ppu_rd      = mem_q[ppu_eff];
        ppu_dout_d  = bus.greyscale ? (ppu_rd & GREY_MASK) : ppu_rd;

        case (state_q)
            ST_INIT: begin
                // Raw counter index, no address translation while clearing.
                mem_we = 1'b1;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.cpu_write) begin
                    mem_we    = 1'b1;
                    mem_waddr = cpu_eff;
                    mem_wdata = bus.cpu_din;
                end
                if (bus.cpu_read) begin
                    cpu_valid_d = 1'b1;
                    // Write-first on the CPU port: a combined access returns the new data.
                    cpu_dout_d  = bus.cpu_write ? bus.cpu_din : mem_q[cpu_eff];
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            cnt_q       <= '0;
            cpu_dout_q  <= '0;
            cpu_valid_q <= 1'b0;
            ppu_dout_q  <= '0;
        end else if (ce_i) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cpu_dout_q  <= cpu_dout_d;
            cpu_valid_q <= cpu_valid_d;
            ppu_dout_q  <= ppu_dout_d;
        end
    end

    // Storage has no reset; contents are established by the clear sequencer.
    always_ff @(posedge clk) begin
        if (!reset && ce_i && mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus.cpu_dout  = cpu_dout_q;
    assign bus.cpu_valid = cpu_valid_q;
    assign bus.ppu_dout  = ppu_dout_q;
    assign bus.busy      = (state_q == ST_INIT);

endmodule
`default_nettype wire

// File: tb/tb_palette_ram_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_palette_ram_ctl
//  Description : Directed self-checking bench for palette_ram_ctl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_palette_ram_ctl;

    localparam int DATA_W = 6;
    localparam int ADDR_W = 5;

    logic clk;
    logic reset;
    logic ce;

    int n_vec;
    int n_err;

    palette_ram_ctl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    palette_ram_ctl #(
        .DATA_W          (DATA_W),
        .ADDR_W          (ADDR_W),
        .MIRROR_BACKDROP (1'b1),
        .INIT_ON_RESET   (1'b1),
        .INIT_VAL        (6'h00),
        .GREY_MASK       (6'h30)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .ce_i  (ce),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [4:0] a, input logic [5:0] d);
        bus.cpu_addr  = a;
        bus.cpu_din   = d;
        bus.cpu_write = 1'b1;
        tick();
        bus.cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [4:0] a);
        bus.cpu_addr = a;
        bus.cpu_read = 1'b1;
        tick();
        bus.cpu_read = 1'b0;
    endtask

    // Ticks until busy falls, bounded; returns the number of ticks taken.
    task automatic wait_busy_fall(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.busy && n < 64);
    endtask

    initial begin
        int n;
        n_vec = 0;
        n_err = 0;
        reset         = 1'b1;
        ce            = 1'b1;
        bus.cpu_addr  = '0;
        bus.cpu_din   = '0;
        bus.cpu_write = 1'b0;
        bus.cpu_read  = 1'b0;
        bus.ppu_addr  = '0;
        bus.greyscale = 1'b0;

        // Reset state
        tick();
        chk("rst_busy",      bus.busy,      1);
        chk("rst_cpu_dout",  bus.cpu_dout,  0);
        chk("rst_cpu_valid", bus.cpu_valid, 0);
        chk("rst_ppu_dout",  bus.ppu_dout,  0);
        reset = 1'b0;

        // Clear takes exactly 32 ce cycles
        wait_busy_fall(n);
        chk("init_len", n, 32);

        // All entries cleared, cpu_valid pulses per read
        for (int a = 0; a < 32; a++) begin
            cpu_rd(a[4:0]);
            chk("clr_valid", bus.cpu_valid, 1);
            chk("clr_data",  bus.cpu_dout,  0);
        end
        tick();
        chk("valid_drop", bus.cpu_valid, 0);

        // Backdrop mirroring
        cpu_wr(5'h10, 6'h2A);
        cpu_rd(5'h00);
        chk("mirror_rd00", bus.cpu_dout, 6'h2A);
        cpu_wr(5'h05, 6'h15);
        cpu_rd(5'h15);
        chk("nomirror_rd15", bus.cpu_dout, 6'h00);
        cpu_rd(5'h05);
        chk("rd05", bus.cpu_dout, 6'h15);
        bus.ppu_addr = 5'h10;
        tick();
        chk("ppu_mirror10", bus.ppu_dout, 6'h2A);

        // Greyscale mask
        cpu_wr(5'h07, 6'h3F);
        bus.ppu_addr  = 5'h07;
        bus.greyscale = 1'b1;
        tick();
        chk("grey_on", bus.ppu_dout, 6'h30);
        bus.greyscale = 1'b0;
        tick();
        chk("grey_off", bus.ppu_dout, 6'h3F);

        // Write / render-read collision: read-first
        bus.ppu_addr = 5'h03;
        cpu_wr(5'h03, 6'h11);
        chk("coll_old", bus.ppu_dout, 6'h00);
        tick();
        chk("coll_new", bus.ppu_dout, 6'h11);

        // Combined read+write: write-first
        bus.cpu_addr  = 5'h08;
        bus.cpu_din   = 6'h22;
        bus.cpu_write = 1'b1;
        bus.cpu_read  = 1'b1;
        tick();
        bus.cpu_write = 1'b0;
        bus.cpu_read  = 1'b0;
        chk("rw_data",  bus.cpu_dout,  6'h22);
        chk("rw_valid", bus.cpu_valid, 1);
        tick();
        chk("rw_valid_drop", bus.cpu_valid, 0);

        // ce=0 with a pending read result: everything frozen
        cpu_wr(5'h01, 6'h2B);
        cpu_rd(5'h01);
        chk("pend_data", bus.cpu_dout, 6'h2B);
        ce = 1'b0;
        bus.ppu_addr = 5'h07;
        for (int i = 0; i < 5; i++) tick();
        chk("frz_valid", bus.cpu_valid, 1);
        chk("frz_cpu",   bus.cpu_dout,  6'h2B);
        chk("frz_ppu",   bus.ppu_dout,  6'h11);
        ce = 1'b1;
        tick();
        chk("unfrz_valid", bus.cpu_valid, 0);
        chk("unfrz_ppu",   bus.ppu_dout,  6'h3F);

        // Reset during RUN, then again at init cycle 10 with a CPU write
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_busy", bus.busy, 1);
        reset = 1'b1;
        bus.cpu_addr  = 5'h1F;
        bus.cpu_din   = 6'h3F;
        bus.cpu_write = 1'b1;
        tick();
        reset = 1'b0;
        wait_busy_fall(n);
        bus.cpu_write = 1'b0;
        chk("reinit_len", n, 32);
        cpu_rd(5'h1F);
        chk("drop_wr", bus.cpu_dout, 6'h00);
        cpu_rd(5'h07);
        chk("recleared07", bus.cpu_dout, 6'h00);

        // ce=0 mid-INIT: counter and busy frozen, reads ignored
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.cpu_read = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("init_rd_valid", bus.cpu_valid, 0);
        bus.cpu_read = 1'b0;
        ce = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("frz_busy", bus.busy, 1);
        ce = 1'b1;
        wait_busy_fall(n);
        chk("resume_len", n, 27);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/palette_ram_ctl.md
# palette_ram_ctl

Parametrised palette memory for the PPU, with a CPU access port, a registered render read port, backdrop mirroring, greyscale masking and a hardware clear sequencer that runs after reset. Sits between the PPU register file (CPU side, $3F00–$3F1F window) and the pixel mux (render side). Replaces the single-port, asynchronous-read palette store. The default parameters give NES geometry: 32 entries of 6 bits.

## Interface
- DATA_W, 6, entry width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- MIRROR_BACKDROP, 1, when 1, any address with addr[1:0]==0 has bit 4 cleared (0x10/14/18/1C alias 0x00/04/08/0C)
- INIT_ON_RESET, 1, when 1, every entry is written with INIT_VAL after reset
- INIT_VAL, 0, value written by the clear sequencer (DATA_W bits)
- GREY_MASK, 6'h30, AND mask applied to render data when greyscale is on
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- ce  in  1  clock enable; all state advances only when ce=1, except reset
- cpu_addr  in  ADDR_W  CPU-side address
- cpu_din  in  DATA_W  CPU write data
- cpu_write  in  1  write strobe, sampled when ce=1
- cpu_read  in  1  read strobe, sampled when ce=1
- cpu_dout  out  DATA_W  registered CPU read data
- cpu_valid  out  1  one-ce-cycle pulse: cpu_dout updated
- ppu_addr  in  ADDR_W  render-side address
- greyscale  in  1  PPUMASK greyscale bit
- ppu_dout  out  DATA_W  registered render data
- busy  out  1  clear sequencer running; CPU access ignored

## Operation
- Address translation is applied identically to both ports: eff = (MIRROR_BACKDROP && a[1:0]==0) ? {a[ADDR_W-1:5], 1'b0, a[3:0]} : a. For ADDR_W<5, mirroring is disabled.
- States: INIT and RUN.
- Reset (any cycle, regardless of ce):
  - outputs cleared: cpu_dout=0, ppu_dout=0, cpu_valid=0
  - init counter cleared to 0
  - state set to INIT if INIT_ON_RESET, else RUN
  - busy=1 in INIT, 0 in RUN
- INIT: each ce cycle writes INIT_VAL to entry[counter] and increments counter (raw index, no translation). After writing entry 2^ADDR_W−1, the block moves to RUN and busy falls.
  - CPU writes and reads are dropped; cpu_valid stays 0.
  - ppu_dout keeps updating from the array.
- RUN, per ce cycle:
  - If cpu_write, mem[eff(cpu_addr)] <= cpu_din.
  - If cpu_read, cpu_dout <= mem[eff(cpu_addr)] and cpu_valid <= 1. Otherwise cpu_valid <= 0.
  - If cpu_read and cpu_write are both set, the read returns the new cpu_din (write-first).
- Render port, every ce cycle in either state: ppu_dout <= greyscale ? (mem[eff(ppu_addr)] & GREY_MASK) : mem[eff(ppu_addr)].
- Same-cycle collision between a CPU write and a render read at the same effective address: ppu_dout returns the old data (read-first). The new data is visible on the next ce.
- Contents are not cleared when INIT_ON_RESET=0; memory holds its power-up value (X in simulation).

## Timing
- CPU read latency is 1 ce cycle. cpu_valid is high for exactly the ce cycle after the request and is cleared on the next ce cycle.
- Render latency is 1 ce cycle, fully pipelined: one new address per ce.
- When ce=0, all registers hold, including the counter, cpu_valid and the outputs.
- Clear time is exactly 2^ADDR_W ce cycles (32 at default). busy falls on the clock edge that performs the final write.
- A reset asserted mid-INIT restarts the counter at 0.
- A reset asserted during RUN re-enters INIT (when INIT_ON_RESET=1).
- busy, cpu_valid and all data outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset, then ce=1 for 32 cycles → busy=1 for 32 cycles then 0; reads of 0x00–0x1F return 0 with cpu_valid pulsing once per read.
- After init, write 0x2A to 0x10, read 0x00 → cpu_dout=0x2A. Write 0x15 to 0x05, read 0x15 → cpu_dout is not 0x15 (no mirror on non-zero low bits).
- Write 0x3F to 0x07; set ppu_addr=0x07 with greyscale=1 → ppu_dout=0x30 one ce later. With greyscale=0 → 0x3F.
- Same cycle: CPU writes 0x11 to 0x03 while ppu_addr=0x03 (old value 0x00) → ppu_dout=0x00, then 0x11 on the next ce. A simultaneous cpu_read+cpu_write of 0x22 → cpu_dout=0x22.
- Reset at init cycle 10, plus a CPU write during INIT → busy stays high for a further 32 ce cycles; the dropped write is absent (reads 0).
- Toggle ce=0 for 5 cycles mid-INIT and during a pending read → counter, busy, cpu_valid and ppu_dout frozen; the sequence resumes unchanged when ce returns.
